serial_sub_16bit: RTL and testbench



---
 rtl/serial_sub_16bit_if.sv | 30 +++
 rtl/serial_sub_16bit.sv | 103 ++++++++++
 tb/tb_serial_sub_16bit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_16bit_if.sv
// Handshake and operand/result bundle for the bit-serial 16-bit subtractor.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow flag.
interface serial_sub_16bit_if;
  logic        start;
  logic [15:0] d_1;
  logic [15:0] d_2;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic        Bout;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf;
`endif

  modport master (
    output start, d_1, d_2,
    input  busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, d_1, d_2,
    output busy, done, Diff, Bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_sub_16bit.sv
// Bit-serial 16-bit subtractor: d_1 - d_2, LSB first, one full-adder cell per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output and its sign-bit flops.
module serial_sub_16bit (
  input logic             clk,
  input logic             rst,
  serial_sub_16bit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      r_state;
  logic [15:0] r_aSh;
  logic [15:0] r_bSh;
  logic [15:0] r_diff;
  logic [3:0]  r_cnt;
  logic        r_carry;
  logic        r_bout;
  logic        r_busy;
  logic        r_done;
  logic        w_sum;
  logic        w_carryNext;
`ifdef SERIAL_SUB_OVF_EN
  logic        r_signA;
  logic        r_signB;
  logic        r_ovf;
`endif

  // Subtraction as a + ~b + 1: the carry starts at 1 and a final carry of 0 means a borrow.
  assign w_sum       = r_aSh[0] ^ ~r_bSh[0] ^ r_carry;
  assign w_carryNext = (r_aSh[0] & ~r_bSh[0]) | ((r_aSh[0] ^ ~r_bSh[0]) & r_carry);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_aSh   <= 16'h0000;
      r_bSh   <= 16'h0000;
      r_diff  <= 16'h0000;
      r_cnt   <= 4'd0;
      r_carry <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_signA <= 1'b0;
      r_signB <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_aSh   <= bus.d_1;
            r_bSh   <= bus.d_2;
            r_carry <= 1'b1;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= RUN;
`ifdef SERIAL_SUB_OVF_EN
            r_signA <= bus.d_1[15];
            r_signB <= bus.d_2[15];
`endif
          end
        end
        RUN: begin
          r_diff  <= {w_sum, r_diff[15:1]};
          r_aSh   <= {1'b0, r_aSh[15:1]};
          r_bSh   <= {1'b0, r_bSh[15:1]};
          r_carry <= w_carryNext;
          r_cnt   <= r_cnt + 4'd1;
          // The last bit's sum is the result sign, so overflow uses w_sum directly.
          if (r_cnt == 4'd15) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bout  <= ~w_carryNext;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= (r_signA != r_signB) & (w_sum != r_signA);
`endif
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Diff = r_diff;
  assign bus.Bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_16bit.sv
// Randomized and directed bench for serial_sub_16bit against an arithmetic reference model.
// Overflow checks are active when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_16bit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_sub_16bit_if ifc ();

  serial_sub_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  int          phase = -1;
  logic [15:0] expDiff = 16'h0000;
  logic [15:0] pendDiff = 16'h0000;
  logic        expBout = 1'b0;
  logic        pendBout = 1'b0;
  logic        expOvf = 1'b0;
  logic        pendOvf = 1'b0;
  logic        expBusy = 1'b0;
  logic        expDone = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: the result is plain modular/integer arithmetic, delivered 16 edges after accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   = -1;
      expBusy = 1'b0;
      expDone = 1'b0;
      expDiff = 16'h0000;
      expBout = 1'b0;
      expOvf  = 1'b0;
    end else if (phase < 0) begin
      expDone = 1'b0;
      if (ifc.start) begin
        int a;
        int b;
        int r;
        a = int'($signed(ifc.d_1));
        b = int'($signed(ifc.d_2));
        r = a - b;
        phase    = 0;
        expBusy  = 1'b1;
        pendDiff = ifc.d_1 - ifc.d_2;
        pendBout = (ifc.d_1 < ifc.d_2);
        pendOvf  = (r > 32767) || (r < -32768);
      end
    end else begin
      phase++;
      if (phase == 16) begin
        expBusy = 1'b0;
        expDone = 1'b1;
        expDiff = pendDiff;
        expBout = pendBout;
        expOvf  = pendOvf;
      end else if (phase == 17) begin
        expDone = 1'b0;
        phase   = -1;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("busy", ifc.busy, expBusy);
    checkOutput("done", ifc.done, expDone);
    checkOutput("busyDoneExclusive", ifc.busy & ifc.done, 1'b0);
    if (!expBusy) begin
      checkOutput("Diff", ifc.Diff, expDiff);
      checkOutput("Bout", ifc.Bout, expBout);
`ifdef SERIAL_SUB_OVF_EN
      checkOutput("ovf", ifc.ovf, expOvf);
`endif
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.d_1   = a;
    ifc.d_2   = b;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.d_1   = 16'($urandom);
    ifc.d_2   = 16'($urandom);
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!ifc.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ifc.done) checkOutput("doneTimeout", 32'(lat), 32'd16);
  endtask

  task automatic runOp(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] diff, input logic bout, input logic ovf);
    int lat;
    applyStimulus(a, b);
    waitDone(lat);
    checkOutput({name, ".latency"}, 32'(lat), 32'd16);
    checkOutput({name, ".Diff"}, ifc.Diff, diff);
    checkOutput({name, ".Bout"}, ifc.Bout, bout);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput({name, ".ovf"}, ifc.ovf, ovf);
`else
    if (ovf) $display("[TB] %s expects overflow; flag not built", name);
`endif
  endtask

  initial begin
    int pulses;
    int lastPulse;
    logic [15:0] seenDiff;

    ifc.start = 1'b0;
    ifc.d_1   = 16'h0000;
    ifc.d_2   = 16'h0000;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", ifc.busy, 1'b0);
    checkOutput("reset.done", ifc.done, 1'b0);
    checkOutput("reset.Diff", ifc.Diff, 16'h0000);
    checkOutput("reset.Bout", ifc.Bout, 1'b0);
    rst = 1'b0;

    runOp("basic",   16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    runOp("underflow", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    runOp("equal",   16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    runOp("ovfNeg",  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    runOp("ovfPos",  16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

    // A start pulse mid-RUN with other operands must be ignored.
    applyStimulus(16'hAAAA, 16'h5555);
    repeat (4) @(negedge clk);
    ifc.start = 1'b1;
    ifc.d_1   = 16'h1111;
    ifc.d_2   = 16'h2222;
    @(negedge clk);
    ifc.start = 1'b0;
    pulses   = 0;
    seenDiff = 16'h0000;
    repeat (30) begin
      @(negedge clk);
      if (ifc.done) begin
        pulses++;
        seenDiff = ifc.Diff;
      end
    end
    checkOutput("ignoreStart.pulses", 32'(pulses), 32'd1);
    checkOutput("ignoreStart.Diff", seenDiff, 16'h5555);

    // Reset in the middle of an operation discards it.
    applyStimulus(16'h1234, 16'h0001);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midReset.busy", ifc.busy, 1'b0);
    checkOutput("midReset.done", ifc.done, 1'b0);
    checkOutput("midReset.Diff", ifc.Diff, 16'h0000);
    checkOutput("midReset.Bout", ifc.Bout, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (ifc.done) pulses++;
    end
    checkOutput("midReset.noDone", 32'(pulses), 32'd0);
    runOp("afterReset", 16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0);

    // Start held high: one result every 18 cycles.
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.d_1   = 16'h0010;
    ifc.d_2   = 16'h0001;
    pulses    = 0;
    lastPulse = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (ifc.done) begin
        pulses++;
        checkOutput("heldStart.Diff", ifc.Diff, 16'h000F);
        if (lastPulse >= 0) checkOutput("heldStart.period", 32'(i - lastPulse), 32'd18);
        lastPulse = i;
      end
    end
    checkOutput("heldStart.pulses", 32'(pulses), 32'd3);
    ifc.start = 1'b0;
    repeat (20) @(negedge clk);

    // Random traffic, checked every cycle against the model.
    repeat (800) begin
      @(negedge clk);
      ifc.start = ($urandom_range(0, 3) == 0);
      ifc.d_1   = 16'($urandom);
      ifc.d_2   = 16'($urandom);
    end
    ifc.start = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
